// File: rtl/packet_switch_avmm_rsp_tracker.sv
// packet_switch_avmm_rsp_tracker
//   Host-facing AVMM agent for the packet switch CSR path. Range-checks host
//   requests against [BASE_ADDR, BASE_ADDR+MAX_ADDR], forwards in-range
//   accesses downstream rebased to offset 0 (one cycle later), and returns
//   read responses strictly in request order. Out-of-range reads get a
//   synthesized ERR_DATA response, so the host never waits forever for
//   readdatavalid.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   host_avmm_*             host-side AVMM agent (address/read/write/
//                           writedata/byteenable in; waitrequest/readdata/
//                           readdatavalid out)
//   slv_avmm_*              downstream CSR window (address/read/write/
//                           writedata/byteenable out; readdata/readdatavalid
//                           in, no backpressure)
//   err_cnt                 saturating count of dropped (out-of-range) accesses
//   unexp_rsp               sticky: downstream data with no in-range read pending
//
// Optional build macro PKT_SW_AVMM_RSP_CODE_EN
//   adds host_avmm_response[1:0]: 2'b00 OKAY / 2'b11 DECODEERROR, valid with
//   readdatavalid, 2'b00 otherwise.
module packet_switch_avmm_rsp_tracker #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h0,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR   = 'h8,
  parameter int unsigned           MAX_PEND   = 8,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   host_avmm_address,
  input  logic                    host_avmm_read,
  input  logic                    host_avmm_write,
  input  logic [DATA_WIDTH-1:0]   host_avmm_writedata,
  input  logic [DATA_WIDTH/8-1:0] host_avmm_byteenable,
  output logic                    host_avmm_waitrequest,
  output logic [DATA_WIDTH-1:0]   host_avmm_readdata,
  output logic                    host_avmm_readdatavalid,
`ifdef PKT_SW_AVMM_RSP_CODE_EN
  output logic [1:0]              host_avmm_response,
`endif
  output logic [ADDR_WIDTH-1:0]   slv_avmm_address,
  output logic                    slv_avmm_read,
  output logic                    slv_avmm_write,
  output logic [DATA_WIDTH-1:0]   slv_avmm_writedata,
  output logic [DATA_WIDTH/8-1:0] slv_avmm_byteenable,
  input  logic [DATA_WIDTH-1:0]   slv_avmm_readdata,
  input  logic                    slv_avmm_readdatavalid,
  output logic [15:0]             err_cnt,
  output logic                    unexp_rsp
);

  localparam int unsigned PW = $clog2(MAX_PEND);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_WIDTH:0] offset;
  logic                oor;
  logic                accept;
  logic                acc_rd;
  logic                acc_wr;

  logic [CW-1:0]       pend_cnt;
  logic [CW-1:0]       ir_cnt;

  logic                tag_mem [MAX_PEND];
  logic [PW-1:0]       tag_wr;
  logic [PW-1:0]       tag_rd;
  logic [CW-1:0]       tag_cnt;

  logic [DATA_WIDTH-1:0] data_mem [MAX_PEND];
  logic [PW-1:0]       data_wr;
  logic [PW-1:0]       data_rd;
  logic [CW-1:0]       data_cnt;
  logic                data_push;

  logic                head_oor;
  logic                pop_tag;
  logic                pop_data;

  // Extra MSB of the subtraction is the borrow: address below the window.
  assign offset = {1'b0, host_avmm_address} - {1'b0, BASE_ADDR};
  assign oor    = offset[ADDR_WIDTH] | (offset[ADDR_WIDTH-1:0] > MAX_ADDR);

  assign host_avmm_waitrequest = (pend_cnt == CW'(MAX_PEND));
  assign accept = (host_avmm_read | host_avmm_write) & ~host_avmm_waitrequest;
  assign acc_rd = accept & host_avmm_read;
  assign acc_wr = accept & host_avmm_write & ~host_avmm_read;

  // Downstream data is only legitimate while an in-range read lacks its data.
  assign data_push = slv_avmm_readdatavalid & (ir_cnt != '0);

  always_comb begin
    head_oor = tag_mem[tag_rd];
    pop_tag  = (tag_cnt != '0) & (head_oor | (data_cnt != '0));
    pop_data = pop_tag & ~head_oor;
  end

  always_ff @(posedge clk) begin
    if (acc_rd)    tag_mem[tag_wr]   <= oor;
    if (data_push) data_mem[data_wr] <= slv_avmm_readdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slv_avmm_address        <= '0;
      slv_avmm_read           <= 1'b0;
      slv_avmm_write          <= 1'b0;
      slv_avmm_writedata      <= '0;
      slv_avmm_byteenable     <= '0;
      host_avmm_readdata      <= '0;
      host_avmm_readdatavalid <= 1'b0;
`ifdef PKT_SW_AVMM_RSP_CODE_EN
      host_avmm_response      <= 2'b00;
`endif
      pend_cnt                <= '0;
      ir_cnt                  <= '0;
      tag_wr                  <= '0;
      tag_rd                  <= '0;
      tag_cnt                 <= '0;
      data_wr                 <= '0;
      data_rd                 <= '0;
      data_cnt                <= '0;
      err_cnt                 <= '0;
      unexp_rsp               <= 1'b0;
    end else begin
      slv_avmm_read  <= acc_rd & ~oor;
      slv_avmm_write <= acc_wr & ~oor;
      if (accept & ~oor) begin
        slv_avmm_address    <= offset[ADDR_WIDTH-1:0];
        slv_avmm_writedata  <= host_avmm_writedata;
        slv_avmm_byteenable <= host_avmm_byteenable;
      end

      if (acc_rd)  tag_wr <= tag_wr + PW'(1);
      if (pop_tag) tag_rd <= tag_rd + PW'(1);
      tag_cnt <= tag_cnt + CW'(acc_rd) - CW'(pop_tag);

      if (data_push) data_wr <= data_wr + PW'(1);
      if (pop_data)  data_rd <= data_rd + PW'(1);
      data_cnt <= data_cnt + CW'(data_push) - CW'(pop_data);

      ir_cnt   <= ir_cnt + CW'(acc_rd & ~oor) - CW'(data_push);
      // Slot frees only once the response has actually left toward the host.
      pend_cnt <= pend_cnt + CW'(acc_rd) - CW'(host_avmm_readdatavalid);

      host_avmm_readdatavalid <= pop_tag;
      if (pop_tag) host_avmm_readdata <= head_oor ? ERR_DATA : data_mem[data_rd];
`ifdef PKT_SW_AVMM_RSP_CODE_EN
      host_avmm_response <= (pop_tag & head_oor) ? 2'b11 : 2'b00;
`endif

      if (accept & oor & (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
      if (slv_avmm_readdatavalid & (ir_cnt == '0)) unexp_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_packet_switch_avmm_rsp_tracker.sv
// Self-checking bench for packet_switch_avmm_rsp_tracker (BASE_ADDR='h40).
// A queue-based reference model predicts every host response from request
// order and trigger times: response i appears at max(trigger_i+2, prev+1).
module tb_packet_switch_avmm_rsp_tracker;
  localparam int          MP   = 8;
  localparam logic [7:0]  BASE = 8'h40;
  localparam logic [7:0]  MAXO = 8'h08;
  localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  host_avmm_address = '0;
  logic        host_avmm_read = 1'b0;
  logic        host_avmm_write = 1'b0;
  logic [31:0] host_avmm_writedata = '0;
  logic [3:0]  host_avmm_byteenable = '0;
  logic        host_avmm_waitrequest;
  logic [31:0] host_avmm_readdata;
  logic        host_avmm_readdatavalid;
`ifdef PKT_SW_AVMM_RSP_CODE_EN
  logic [1:0]  host_avmm_response;
`endif
  logic [7:0]  slv_avmm_address;
  logic        slv_avmm_read;
  logic        slv_avmm_write;
  logic [31:0] slv_avmm_writedata;
  logic [3:0]  slv_avmm_byteenable;
  logic [31:0] slv_avmm_readdata = '0;
  logic        slv_avmm_readdatavalid = 1'b0;
  logic [15:0] err_cnt;
  logic        unexp_rsp;

  always #5 clk = ~clk;

  packet_switch_avmm_rsp_tracker #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .BASE_ADDR(BASE), .MAX_ADDR(MAXO),
    .MAX_PEND(MP), .ERR_DATA(ERR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_avmm_address(host_avmm_address), .host_avmm_read(host_avmm_read),
    .host_avmm_write(host_avmm_write), .host_avmm_writedata(host_avmm_writedata),
    .host_avmm_byteenable(host_avmm_byteenable),
    .host_avmm_waitrequest(host_avmm_waitrequest),
    .host_avmm_readdata(host_avmm_readdata),
    .host_avmm_readdatavalid(host_avmm_readdatavalid),
`ifdef PKT_SW_AVMM_RSP_CODE_EN
    .host_avmm_response(host_avmm_response),
`endif
    .slv_avmm_address(slv_avmm_address), .slv_avmm_read(slv_avmm_read),
    .slv_avmm_write(slv_avmm_write), .slv_avmm_writedata(slv_avmm_writedata),
    .slv_avmm_byteenable(slv_avmm_byteenable),
    .slv_avmm_readdata(slv_avmm_readdata),
    .slv_avmm_readdatavalid(slv_avmm_readdatavalid),
    .err_cnt(err_cnt), .unexp_rsp(unexp_rsp)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    bit          oor;
    bit          known;
    int          t;
    logic [31:0] data;
  } rsp_t;

  rsp_t        rq[$];
  int          sq[$];
  logic [31:0] seen[$];
  int          last_r = -10;
  logic [31:0] last_data = '0;
  int          err_m = 0;
  bit          unexp_m = 0;
  bit          exp_wait = 0;
  bit          fwd_v = 0;
  int          fwd_c = 0;
  bit          fwd_rd = 0;
  logic [7:0]  fwd_a = '0;
  logic [31:0] fwd_d = '0;
  logic [3:0]  fwd_be = '0;
  bit          auto_slave = 0;
  bit          last_acc = 0;
  int          acc_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  function automatic bit is_oor(input logic [7:0] a);
    int off;
    off = int'(a) - int'(BASE);
    return (off < 0) || (off > int'(MAXO));
  endfunction

  task automatic check_cycle();
    bit          exp_v;
    logic [31:0] exp_d;
    logic [1:0]  exp_code;
    int          rdy;
    exp_wait = (rq.size() == MP);
    chk("waitrequest", host_avmm_waitrequest, exp_wait);
    exp_v = 0; exp_d = last_data; exp_code = 2'b00;
    if (rq.size() > 0 && rq[0].known) begin
      rdy = (rq[0].t + 2 > last_r + 1) ? rq[0].t + 2 : last_r + 1;
      if (rdy <= cyc) begin
        exp_v = 1; exp_d = rq[0].data; exp_code = rq[0].oor ? 2'b11 : 2'b00;
        void'(rq.pop_front());
        last_r = cyc; last_data = exp_d;
      end
    end
    chk("readdatavalid", host_avmm_readdatavalid, exp_v);
    chk("readdata", host_avmm_readdata, exp_d);
`ifdef PKT_SW_AVMM_RSP_CODE_EN
    chk("response", host_avmm_response, exp_code);
`endif
    if (host_avmm_readdatavalid) seen.push_back(host_avmm_readdata);
    if (fwd_v && fwd_c == cyc) begin
      chk("slv_read", slv_avmm_read, fwd_rd);
      chk("slv_write", slv_avmm_write, !fwd_rd);
      chk("slv_address", slv_avmm_address, fwd_a);
      if (!fwd_rd) begin
        chk("slv_writedata", slv_avmm_writedata, fwd_d);
        chk("slv_byteenable", slv_avmm_byteenable, fwd_be);
      end
      fwd_v = 0;
    end else begin
      chk("slv_read idle", slv_avmm_read, 0);
      chk("slv_write idle", slv_avmm_write, 0);
    end
    if (auto_slave && slv_avmm_read) sq.push_back(cyc + $urandom_range(1, 5));
    chk("err_cnt", err_cnt, err_m);
    chk("unexp_rsp", unexp_rsp, unexp_m);
  endtask

  // Commit the current cycle's inputs to the model, advance one clock, check.
  task automatic step();
    bit acc, oor, bound;
    if (auto_slave) begin
      if (sq.size() > 0 && sq[0] <= cyc) begin
        void'(sq.pop_front());
        slv_avmm_readdatavalid = 1'b1;
        slv_avmm_readdata = $urandom;
      end else begin
        slv_avmm_readdatavalid = 1'b0;
      end
    end
    if (slv_avmm_readdatavalid) begin
      bound = 0;
      foreach (rq[i]) begin
        if (!bound && !rq[i].oor && !rq[i].known) begin
          rq[i].known = 1; rq[i].t = cyc; rq[i].data = slv_avmm_readdata; bound = 1;
        end
      end
      if (!bound) unexp_m = 1;
    end
    acc = (host_avmm_read || host_avmm_write) && !exp_wait;
    last_acc = acc;
    if (acc) begin
      acc_cyc = cyc;
      oor = is_oor(host_avmm_address);
      if (oor) begin
        if (err_m < 'hFFFF) err_m++;
      end else begin
        fwd_v = 1; fwd_c = cyc + 1; fwd_rd = host_avmm_read;
        fwd_a = host_avmm_address - BASE;
        fwd_d = host_avmm_writedata; fwd_be = host_avmm_byteenable;
      end
      if (host_avmm_read) begin
        rsp_t e;
        e.oor = oor; e.known = oor; e.t = cyc; e.data = oor ? ERR : 32'h0;
        rq.push_back(e);
      end
    end
    @(posedge clk); #1; cyc++;
    check_cycle();
  endtask

  task automatic req(input bit rd, input bit wr, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    host_avmm_read = rd; host_avmm_write = wr; host_avmm_address = a;
    host_avmm_writedata = d; host_avmm_byteenable = be;
  endtask

  task automatic idle();
    host_avmm_read = 1'b0; host_avmm_write = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    slv_avmm_readdatavalid = 1'b0;
    rq.delete(); sq.delete();
    err_m = 0; unexp_m = 0; fwd_v = 0; last_data = '0; last_r = -10; exp_wait = 0;
    @(posedge clk); #1; cyc++;
    check_cycle();
    chk("reset slv_address", slv_avmm_address, 0);
    chk("reset slv_writedata", slv_avmm_writedata, 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    bit          fwd;
    logic [7:0]  off;
  } wvec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wvec_t wt[8];
    int    err_exp, acc9, d_cyc, hold;
    bit    got, have, rrd;
    logic [7:0]  ra;
    logic [31:0] rd_d;
    logic [3:0]  rbe;

    wt[0] = '{a:8'h49, d:32'h1111, be:4'hF, fwd:0, off:8'h00};
    wt[1] = '{a:8'h48, d:32'hCAFE, be:4'h3, fwd:1, off:8'h08};
    wt[2] = '{a:8'h40, d:32'h55AA, be:4'hF, fwd:1, off:8'h00};
    wt[3] = '{a:8'h3F, d:32'h0001, be:4'h1, fwd:0, off:8'h00};
    wt[4] = '{a:8'h00, d:32'h0002, be:4'hF, fwd:0, off:8'h00};
    wt[5] = '{a:8'hFF, d:32'h0003, be:4'hF, fwd:0, off:8'h00};
    wt[6] = '{a:8'h47, d:32'h7777, be:4'hC, fwd:1, off:8'h07};
    wt[7] = '{a:8'hC8, d:32'h0004, be:4'hF, fwd:0, off:8'h00};

    // In-range read: forward next cycle, response two cycles after slave data.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) req(1, 0, 8'h44, 0, 4'hF); else idle();
      slv_avmm_readdatavalid = (k == 3);
      slv_avmm_readdata = 32'h1234_5678;
      step();
      if (k == 0) begin
        chk("tp1 slv_read", slv_avmm_read, 1);
        chk("tp1 slv_address", slv_avmm_address, 8'h04);
      end
      if (k == 4) begin
        chk("tp1 readdatavalid", host_avmm_readdatavalid, 1);
        chk("tp1 readdata", host_avmm_readdata, 32'h1234_5678);
      end
    end
    slv_avmm_readdatavalid = 1'b0;

    // Below-base read: synthesized error two cycles after acceptance.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) req(1, 0, 8'h20, 0, 4'hF); else idle();
      step();
      if (k == 0) chk("tp2 no slv_read", slv_avmm_read, 0);
      if (k == 1) begin
        chk("tp2 readdatavalid", host_avmm_readdatavalid, 1);
        chk("tp2 readdata", host_avmm_readdata, ERR);
        chk("tp2 err_cnt", err_cnt, 1);
`ifdef PKT_SW_AVMM_RSP_CODE_EN
        chk("tp2 response", host_avmm_response, 2'b11);
`endif
      end
    end

    // Mixed in-range/oor back-to-back: responses keep request order.
    do_reset();
    seen.delete();
    for (int k = 0; k < 14; k++) begin
      case (k)
        0: req(1, 0, 8'h41, 0, 4'hF);
        1: req(1, 0, 8'h50, 0, 4'hF);
        2: req(1, 0, 8'h42, 0, 4'hF);
        default: idle();
      endcase
      slv_avmm_readdatavalid = (k == 4) || (k == 7);
      slv_avmm_readdata = (k == 4) ? 32'hA : 32'hB;
      step();
    end
    slv_avmm_readdatavalid = 1'b0;
    chk("tp3 response count", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("tp3 first", seen[0], 32'hA);
      chk("tp3 second", seen[1], ERR);
      chk("tp3 third", seen[2], 32'hB);
    end

    // Fill all pending slots, hold a 9th read, release with one response.
    do_reset();
    for (int i = 0; i < MP; i++) begin
      req(1, 0, BASE + 8'(i), 0, 4'hF);
      step();
      chk("tp4 fill accepted", last_acc, 1);
    end
    idle();
    chk("tp4 waitrequest full", host_avmm_waitrequest, 1);
    got = 0; acc9 = -1; d_cyc = 0;
    for (int k = 0; k < 10; k++) begin
      if (!got) req(1, 0, 8'h48, 0, 4'hF); else idle();
      slv_avmm_readdatavalid = (k == 2);
      slv_avmm_readdata = 32'h0BAD_F00D;
      if (k == 2) d_cyc = cyc;
      step();
      if (last_acc && !got) begin got = 1; acc9 = acc_cyc; end
    end
    slv_avmm_readdatavalid = 1'b0;
    idle();
    chk("tp4 9th accept cycle", acc9, d_cyc + 3);

    // Write table: range check, rebasing, drop and error counting.
    do_reset();
    err_exp = 0;
    for (int i = 0; i < 8; i++) begin
      req(0, 1, wt[i].a, wt[i].d, wt[i].be);
      step();
      idle();
      if (!wt[i].fwd) err_exp++;
      chk("wr slv_write", slv_avmm_write, wt[i].fwd);
      if (wt[i].fwd) begin
        chk("wr slv_address", slv_avmm_address, wt[i].off);
        chk("wr slv_writedata", slv_avmm_writedata, wt[i].d);
        chk("wr slv_byteenable", slv_avmm_byteenable, wt[i].be);
      end
      chk("wr err_cnt", err_cnt, err_exp);
      step();
    end
    // Unsolicited downstream data: sticky flag, no host response.
    seen.delete();
    slv_avmm_readdatavalid = 1'b1; slv_avmm_readdata = 32'h99;
    step();
    slv_avmm_readdatavalid = 1'b0;
    chk("unexp set", unexp_rsp, 1);
    for (int k = 0; k < 4; k++) step();
    chk("unexp no response", seen.size(), 0);

    // Reset with reads outstanding discards them; late data is unexpected.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req(1, 0, 8'h41 + 8'(i), 0, 4'hF);
      step();
    end
    idle();
    step();
    do_reset();
    chk("mid reset readdatavalid", host_avmm_readdatavalid, 0);
    chk("mid reset waitrequest", host_avmm_waitrequest, 0);
    seen.delete();
    step();
    slv_avmm_readdatavalid = 1'b1; slv_avmm_readdata = 32'h5555;
    step();
    slv_avmm_readdatavalid = 1'b0;
    chk("late data unexp", unexp_rsp, 1);
    for (int k = 0; k < 4; k++) step();
    chk("late data no response", seen.size(), 0);

    // Randomized traffic against the model with an in-order random-latency slave.
    do_reset();
    auto_slave = 1;
    have = 0; hold = 0; rrd = 0; ra = '0; rd_d = '0; rbe = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!have && $urandom_range(0, 1) == 1) begin
        have = 1; hold = 0;
        rrd  = ($urandom_range(0, 9) < 7);
        ra   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(8'h38, 8'h50));
        rd_d = $urandom; rbe = 4'($urandom);
      end
      if (have) req(rrd, !rrd, ra, rd_d, rbe); else idle();
      step();
      if (have) begin
        if (last_acc) have = 0;
        else begin
          hold++;
          if (hold > 100) begin fail_timeout("random request held"); have = 0; end
        end
      end
    end
    idle();
    for (int k = 0; k < 60; k++) step();
    auto_slave = 0;
    slv_avmm_readdatavalid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
